// File: rtl/box_animator_if.sv
// Square-plot command channel between the box animator and the pixel plotter.
interface box_animator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [2:0] cmd_colour;
    logic       plot_done;

    modport master (
        output cmd_valid,
        output cmd_x,
        output cmd_y,
        output cmd_colour,
        input  cmd_ready,
        input  plot_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_x,
        input  cmd_y,
        input  cmd_colour,
        output cmd_ready,
        output plot_done
    );
endinterface

// File: rtl/box_animator.sv
// Bouncing-box animator: draws a square, holds it for a number of frames,
// erases it, steps it one pixel diagonally with edge bounce, and repeats.
//
//   state      | meaning
//   DRAW_REQ   | offer draw of box at (px,py) in latched colour
//   DRAW_WAIT  | draw accepted, waiting for plot_done
//   HOLD       | count run-qualified frame ticks up to FRAMES_PER_STEP
//   ERASE_REQ  | offer erase (colour 000) of box at (px,py)
//   ERASE_WAIT | erase accepted, waiting for plot_done
//   MOVE       | bounce direction at limits, step px/py by one
module box_animator #(
    parameter int CLKS_PER_FRAME  = 833333,
    parameter int FRAMES_PER_STEP = 15,
    parameter int BOX             = 4,
    parameter int X_LIM           = 160,
    parameter int Y_LIM           = 120
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run,
    input  logic [2:0]      colour_in,
    output logic            frame_tick,
    box_animator_if.master  cmd
);

    localparam int FW = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
    localparam int SW = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [7:0] X_MAX = 8'(X_LIM - BOX);
    localparam logic [6:0] Y_MAX = 7'(Y_LIM - BOX);

    typedef enum logic [2:0] {
        DRAW_REQ,
        DRAW_WAIT,
        HOLD,
        ERASE_REQ,
        ERASE_WAIT,
        MOVE
    } state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [SW-1:0]   step_q, step_d;
    logic [SW-1:0]   step_inc;
    logic [7:0]      px_q, px_d;
    logic [6:0]      py_q, py_d;
    logic            dx_q, dx_d;
    logic            dy_q, dy_d;
    logic            ndx, ndy;
    logic [2:0]      colour_q, colour_d;
    // live_q keeps the command channel quiet for the cycle following a reset edge
    logic            live_q, live_d;
    logic            in_req;
    logic            accept;

    assign frame_tick     = (frame_q == FW'(CLKS_PER_FRAME - 1));
    assign in_req         = live_q && ((state_q == DRAW_REQ) || (state_q == ERASE_REQ));
    assign accept         = in_req && cmd.cmd_ready;
    assign step_inc       = step_q + SW'(1);

    assign cmd.cmd_valid  = in_req;
    assign cmd.cmd_x      = px_q;
    assign cmd.cmd_y      = py_q;
    assign cmd.cmd_colour = (!live_q || (state_q == ERASE_REQ)) ? 3'b000 : colour_q;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_tick ? '0 : frame_q + FW'(1);
        step_d   = step_q;
        px_d     = px_q;
        py_d     = py_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        colour_d = colour_q;
        live_d   = 1'b1;
        ndx      = dx_q;
        ndy      = dy_q;

        case (state_q)
            DRAW_REQ: begin
                if (accept) state_d = DRAW_WAIT;
            end
            DRAW_WAIT: begin
                if (cmd.plot_done) begin
                    state_d = HOLD;
                    step_d  = '0;
                end
            end
            HOLD: begin
                if (frame_tick && run) begin
                    step_d = step_inc;
                    if (step_inc == SW'(FRAMES_PER_STEP)) state_d = ERASE_REQ;
                end
            end
            ERASE_REQ: begin
                if (accept) state_d = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (cmd.plot_done) state_d = MOVE;
            end
            MOVE: begin
                // Bounce is decided on the pre-step position so the box never leaves the screen
                if ((dx_q && (px_q == X_MAX)) || (!dx_q && (px_q == 8'd0))) ndx = ~dx_q;
                if ((dy_q && (py_q == Y_MAX)) || (!dy_q && (py_q == 7'd0))) ndy = ~dy_q;
                dx_d     = ndx;
                dy_d     = ndy;
                px_d     = ndx ? px_q + 8'd1 : px_q - 8'd1;
                py_d     = ndy ? py_q + 7'd1 : py_q - 7'd1;
                colour_d = colour_in;
                state_d  = DRAW_REQ;
            end
            default: state_d = DRAW_REQ;
        endcase

        if (!resetn) begin
            state_d  = DRAW_REQ;
            frame_d  = '0;
            step_d   = '0;
            px_d     = 8'd0;
            py_d     = 7'd0;
            dx_d     = 1'b1;
            dy_d     = 1'b1;
            colour_d = colour_in;
            live_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        frame_q  <= frame_d;
        step_q   <= step_d;
        px_q     <= px_d;
        py_q     <= py_d;
        dx_q     <= dx_d;
        dy_q     <= dy_d;
        colour_q <= colour_d;
        live_q   <= live_d;
    end

endmodule

// File: tb/tb_box_animator.sv
// Self-checking bench for box_animator: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_box_animator;

    localparam int CPF = 4;
    localparam int FPS = 2;
    localparam int BOX = 4;
    localparam int XL  = 8;
    localparam int YL  = 6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b1;
    logic [2:0] colour_in = 3'b101;
    logic       frame_tick;

    box_animator_if bus();

    box_animator #(
        .CLKS_PER_FRAME (CPF),
        .FRAMES_PER_STEP(FPS),
        .BOX            (BOX),
        .X_LIM          (XL),
        .Y_LIM          (YL)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .colour_in (colour_in),
        .frame_tick(frame_tick),
        .cmd       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: phase 0 offer, 1 plotting, 2 holding, 3 moving
    int         m_fcnt = 0;
    int         m_px = 0, m_py = 0;
    bit         m_dx = 1, m_dy = 1;
    bit         m_live = 0, m_erase = 0;
    int         m_ph = 0;
    int         m_steps = 0;
    logic [2:0] m_col = 3'b101;

    // Stimulus controls
    int rdy_mode = 0;
    bit run_v = 1, rst_v = 1, spur_en = 0, rand_col = 0;
    int pd_fixed = 3;
    int pd_cnt = 0;

    typedef struct { int x; int y; int c; } rec_t;
    rec_t acc_q[$];

    bit o_valid, o_tick;

    task automatic step();
        bit ev, rn, rdy, rv, pd, acc, tk;
        logic [2:0] col;
        rec_t r;
        @(negedge clk);
        ev = m_live && (m_ph == 0);
        check("frame_tick", frame_tick, (m_fcnt == CPF - 1));
        check("cmd_valid", bus.cmd_valid, ev);
        if (ev || !m_live) begin
            check("cmd_x", bus.cmd_x, ev ? m_px : 0);
            check("cmd_y", bus.cmd_y, ev ? m_py : 0);
            check("cmd_colour", bus.cmd_colour, (ev && !m_erase) ? m_col : 3'b000);
        end
        o_valid = bus.cmd_valid;
        o_tick  = frame_tick;

        rn = !rst_v;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        rv  = run_v;
        col = rand_col ? 3'($urandom_range(0, 7)) : colour_in;
        pd  = 1'b0;
        if (pd_cnt > 0) begin
            pd_cnt--;
            pd = (pd_cnt == 0);
        end else if (spur_en && $urandom_range(0, 3) == 0) begin
            pd = 1'b1;
        end
        acc = rn && ev && rdy;
        if (!rn) pd_cnt = 0;
        else if (acc) begin
            pd_cnt = (pd_fixed > 0) ? pd_fixed : int'($urandom_range(1, 6));
            r.x = m_px;
            r.y = m_py;
            r.c = m_erase ? 0 : int'(m_col);
            acc_q.push_back(r);
        end

        resetn        = rn;
        bus.cmd_ready = rdy;
        run           = rv;
        colour_in     = col;
        bus.plot_done = pd;

        if (!rn) begin
            m_fcnt = 0; m_px = 0; m_py = 0; m_dx = 1; m_dy = 1;
            m_ph = 0; m_erase = 0; m_steps = 0; m_live = 0; m_col = col;
        end else begin
            tk = (m_fcnt == CPF - 1);
            m_fcnt = (m_fcnt + 1) % CPF;
            case (m_ph)
                0: if (acc) m_ph = 1;
                1: if (pd) begin
                       if (m_erase) m_ph = 3;
                       else begin m_ph = 2; m_steps = 0; end
                   end
                2: if (tk && rv) begin
                       m_steps++;
                       if (m_steps == FPS) begin m_ph = 0; m_erase = 1; end
                   end
                default: begin
                    if (m_dx ? (m_px == XL - BOX) : (m_px == 0)) m_dx = !m_dx;
                    if (m_dy ? (m_py == YL - BOX) : (m_py == 0)) m_dy = !m_dy;
                    m_px += m_dx ? 1 : -1;
                    m_py += m_dy ? 1 : -1;
                    m_ph = 0; m_erase = 0; m_col = col;
                end
            endcase
            m_live = 1;
        end
    endtask

    initial begin
        int n, ticks, vcnt, n0;
        int ex[7] = '{0, 1, 2, 3, 4, 3, 2};
        int ey[7] = '{0, 1, 2, 1, 0, 1, 2};
        logic [7:0] cx;
        logic [6:0] cy;
        logic [2:0] cc;
        bus.cmd_ready = 1'b0;
        bus.plot_done = 1'b0;

        // Reset, then six steps of free animation with immediate ready
        repeat (3) step();
        rst_v = 0;
        n = 0;
        while (acc_q.size() < 13 && n < 2000) begin step(); n++; end
        check("wait_seven_draws", (n < 2000), 1);
        if (acc_q.size() >= 13) begin
            for (int i = 0; i < 7; i++) begin
                check($sformatf("draw%0d_x", i), acc_q[2*i].x, ex[i]);
                check($sformatf("draw%0d_y", i), acc_q[2*i].y, ey[i]);
                check($sformatf("draw%0d_col", i), acc_q[2*i].c, 5);
            end
            check("erase0_x", acc_q[1].x, 0);
            check("erase0_y", acc_q[1].y, 0);
            check("erase0_col", acc_q[1].c, 0);
            check("erase1_x", acc_q[3].x, 1);
            check("erase1_col", acc_q[3].c, 0);
        end

        // Backpressure on a draw offer for 10 cycles
        n = 0;
        while (m_ph != 3 && n < 200) begin step(); n++; end
        check("wait_move", (n < 200), 1);
        rdy_mode = 1;
        step();
        step();
        cx = bus.cmd_x; cy = bus.cmd_y; cc = bus.cmd_colour;
        check("stall_valid_first", o_valid, 1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("stall_valid", o_valid, 1);
            check("stall_x", bus.cmd_x, cx);
            check("stall_y", bus.cmd_y, cy);
            check("stall_col", bus.cmd_colour, cc);
        end
        rdy_mode = 0;

        // run=0 during draw wait: draw completes, hold stalls despite spurious plot_done
        n = 0;
        while (!(m_ph == 1 && !m_erase) && n < 200) begin step(); n++; end
        check("wait_draw_plot", (n < 200), 1);
        run_v = 0;
        spur_en = 1;
        vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (o_valid) vcnt++;
        end
        check("frozen_no_offer", vcnt, 0);
        run_v = 1;
        spur_en = 0;
        ticks = 0;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (o_valid) break;
            if (o_tick) ticks++;
        end
        check("resume_offer_seen", o_valid, 1);
        check("resume_ticks", ticks, FPS);

        // Reset during erase wait
        n = 0;
        while (!(m_ph == 1 && m_erase) && n < 200) begin step(); n++; end
        check("wait_erase_plot", (n < 200), 1);
        rand_col = 0;
        colour_in = 3'b011;
        rst_v = 1;
        step();
        rst_v = 0;
        rand_col = 1;
        n0 = acc_q.size();
        step();
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_x", bus.cmd_x, 0);
        check("rst_y", bus.cmd_y, 0);
        check("rst_col", bus.cmd_colour, 0);
        check("rst_tick", frame_tick, 0);
        n = 0;
        while (acc_q.size() <= n0 && n < 50) begin step(); n++; end
        check("wait_post_rst_cmd", (n < 50), 1);
        if (acc_q.size() > n0) begin
            check("post_rst_x", acc_q[n0].x, 0);
            check("post_rst_y", acc_q[n0].y, 0);
            check("post_rst_col", acc_q[n0].c, 3);
        end

        // Random traffic
        rdy_mode = 2;
        pd_fixed = 0;
        spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            run_v = ($urandom_range(0, 9) != 0);
            rst_v = ($urandom_range(0, 999) == 0);
            step();
        end
        rst_v = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
